// File: rtl/ahb_lite_master.sv
// ahb_lite_master
//   Single-outstanding AHB-Lite master bridge. Turns one valid/ready register
//   request into one AHB SINGLE transfer and reports the outcome on a
//   valid/ready response channel.
//
// Ports
//   HCLK, HRESET            clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake (req_ready high only when idle)
//   req_wr1_rd0, req_addr,
//   req_size, req_wdata     request payload (size 0..2, address must be aligned)
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata, rsp_err      read data (0 for writes/errors), error flag
//   HADDR..HWDATA           registered AHB master outputs
//   HREADY, HRESP, HRDATA   AHB slave returns
module ahb_lite_master #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int MAX_RETRY      = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr1_rd0,
  input  logic [AHB_ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]                req_size,
  input  logic [AHB_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [AHB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic [AHB_ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]                HTRANS,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  output logic [AHB_DATA_WIDTH-1:0] HWDATA,
  input  logic                      HREADY,
  input  logic [1:0]                HRESP,
  input  logic [AHB_DATA_WIDTH-1:0] HRDATA
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_ERROR   = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ERR2,
    S_RTY2,
    S_RESP
  } state_t;

  state_t                    state_q, state_d;
  logic [AHB_ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [1:0]                htrans_q, htrans_d;
  logic                      hwrite_q, hwrite_d;
  logic [2:0]                hsize_q, hsize_d;
  logic [AHB_DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [AHB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [3:0]                retry_cnt_q, retry_cnt_d;

  logic                      accept;
  logic                      req_legal;
  logic [4:0]                retry_inc;
  logic                      retry_exhausted;

  assign accept          = req_valid && (state_q == S_IDLE);
  assign retry_inc       = {1'b0, retry_cnt_q} + 5'd1;
  assign retry_exhausted = (retry_inc >= 5'(MAX_RETRY));

  // Legal sizes are byte/half/word, and the address must be naturally aligned.
  always_comb begin
    req_legal = 1'b0;
    case (req_size)
      3'd0:    req_legal = 1'b1;
      3'd1:    req_legal = (req_addr[0] == 1'b0);
      3'd2:    req_legal = (req_addr[1:0] == 2'b00);
      default: req_legal = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      haddr_q     <= '0;
      htrans_q    <= TRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'd0;
      hwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      retry_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = req_legal ? S_ADDR : S_RESP;
      end
      S_ADDR: begin
        if (HREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (HREADY) begin
          // A non-OKAY response with HREADY high is a slave protocol
          // violation; it completes at once as an error.
          state_d = S_RESP;
        end else if (HRESP == RESP_ERROR) begin
          state_d = S_ERR2;
        end else if (HRESP != RESP_OKAY) begin
          state_d = S_RTY2;
        end
      end
      S_ERR2: begin
        if (HREADY) state_d = S_RESP;
      end
      S_RTY2: begin
        // SPLIT is treated exactly like RETRY: there is no grant logic here.
        if (HREADY) state_d = retry_exhausted ? S_RESP : S_ADDR;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    retry_cnt_d = retry_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          haddr_d  = req_addr;
          hwrite_d = req_wr1_rd0;
          hsize_d  = req_size;
          hwdata_d = req_wdata;
          if (!req_legal) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      S_DATA: begin
        if (HREADY) begin
          rsp_err_d   = (HRESP != RESP_OKAY);
          rsp_rdata_d = ((HRESP == RESP_OKAY) && !hwrite_q) ? HRDATA : '0;
        end
      end
      S_ERR2: begin
        if (HREADY) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      S_RTY2: begin
        if (HREADY) begin
          retry_cnt_d = retry_inc[3:0];
          if (retry_exhausted) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          retry_cnt_d = 4'd0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: ;
    endcase
    // NONSEQ is driven exactly while the FSM sits in the address phase.
    htrans_d = (state_d == S_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = 3'b000;
  assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master
//   Bench for ahb_lite_master: a scripted AHB slave, per-feature test tasks
//   and a transaction-level reference model (latency, issue count, result).
module tb_ahb_lite_master;

  localparam int MAX_RETRY = 4;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_valid, req_ready, req_wr1_rd0;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE, HBURST;

  int total = 0;
  int bad   = 0;

  ahb_lite_master #(
    .AHB_ADDR_WIDTH(32),
    .AHB_DATA_WIDTH(32),
    .MAX_RETRY     (MAX_RETRY)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr1_rd0(req_wr1_rd0),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA)
  );

  always #5 HCLK = ~HCLK;

  // Reference model: outcome of one request given the slave script.
  // kind: 0 = OKAY, 1 = two-cycle ERROR, 2 = ERROR with HREADY high.
  // Each RETRY/SPLIT attempt costs 3 cycles (address, retry, retry-ready).
  function automatic void model(input bit wr, input logic [31:0] addr,
                                input logic [2:0] size, input int awaits,
                                input int nwait, input int retries, input int kind,
                                input logic [31:0] rdata, output int e_lat,
                                output int e_issues, output logic [31:0] e_rdata,
                                output logic e_err);
    if (size > 3'd2 || (addr % (32'd1 << size)) != 0) begin
      e_lat = 1; e_issues = 0; e_rdata = 0; e_err = 1'b1;
    end else if (retries >= MAX_RETRY) begin
      e_issues = MAX_RETRY;
      e_lat    = awaits + 3 * MAX_RETRY + 1;
      e_rdata  = 0; e_err = 1'b1;
    end else begin
      e_issues = retries + 1;
      e_lat    = awaits + 3 * retries + nwait + 3 + ((kind == 1) ? 1 : 0);
      e_err    = (kind != 0);
      e_rdata  = (kind == 0 && !wr) ? rdata : 32'd0;
    end
  endfunction

  // Drive one request, act as the slave, record what the DUT did.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input int awaits, input int nwait,
                         input int retries, input int kind, input logic [31:0] rdata,
                         input int bp, output int lat, output int issues,
                         output logic [31:0] o_rdata, output logic o_err,
                         output int bad_ctrl, output int bad_stable);
    int cyc, dcyc, attempt, aw;
    bit in_data;
    logic [1:0] rcode;
    lat = -1; issues = 0; o_rdata = 'x; o_err = 1'bx; bad_ctrl = 0; bad_stable = 0;
    cyc = 1; dcyc = 0; attempt = 0; aw = awaits; in_data = 0; rcode = 2'b10;
    @(negedge HCLK);
    if (req_ready !== 1'b1) bad_ctrl++;
    req_valid = 1'b1; req_wr1_rd0 = wr; req_addr = addr; req_size = size;
    req_wdata = wdata; rsp_ready = 1'b0; HREADY = 1'b1; HRESP = 2'b00;
    @(negedge HCLK);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 3'($urandom);
    while (cyc < 300) begin
      if (rsp_valid === 1'b1) begin
        lat = cyc; o_rdata = rsp_rdata; o_err = rsp_err;
        break;
      end
      if (req_ready !== 1'b0) bad_ctrl++;
      if (wr && HWDATA !== wdata) bad_stable++;
      if (HBURST !== 3'b000) bad_ctrl++;
      HRDATA = $urandom;
      if (HTRANS === 2'b10) begin
        if (HADDR !== addr || HWRITE !== wr || HSIZE !== size || in_data) bad_ctrl++;
        HRESP = 2'b00;
        if (aw > 0) begin
          HREADY = 1'b0; aw--;
        end else begin
          HREADY = 1'b1; issues++; in_data = 1; dcyc = 0;
        end
      end else if (in_data) begin
        if (HTRANS !== 2'b00) bad_ctrl++;
        if (attempt < retries) begin
          if (dcyc == 0) begin
            rcode = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
            HREADY = 1'b0; HRESP = rcode;
          end else begin
            HREADY = 1'b1; HRESP = rcode; in_data = 0; attempt++;
          end
        end else if (dcyc < nwait) begin
          HREADY = 1'b0; HRESP = 2'b00;
        end else if (kind == 0) begin
          HREADY = 1'b1; HRESP = 2'b00; HRDATA = rdata; in_data = 0;
        end else if (kind == 1 && dcyc == nwait) begin
          HREADY = 1'b0; HRESP = 2'b01;
        end else begin
          HREADY = 1'b1; HRESP = 2'b01; in_data = 0;
        end
        dcyc++;
      end else begin
        if (HTRANS !== 2'b00) bad_ctrl++;
        HREADY = 1'b1; HRESP = 2'b00;
      end
      @(negedge HCLK);
      cyc++;
    end
    if (lat < 0) begin
      // No response within budget: recover with a reset pulse.
      HRESET = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
    end else begin
      HREADY = 1'b1; HRESP = 2'b00;
      for (int i = 0; i < bp; i++) begin
        rsp_ready = 1'b0;
        @(negedge HCLK);
        if (rsp_valid !== 1'b1 || rsp_rdata !== o_rdata || rsp_err !== o_err ||
            req_ready !== 1'b0) bad_stable++;
      end
      rsp_ready = 1'b1;
      @(negedge HCLK);
      rsp_ready = 1'b0;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || HTRANS !== 2'b00) bad_ctrl++;
    end
  endtask

  task automatic test_reset;
    HRESET = 1'b1; req_valid = 1'b0; req_wr1_rd0 = 1'b0; req_addr = '0;
    req_size = '0; req_wdata = '0; rsp_ready = 1'b0; HREADY = 1'b1;
    HRESP = 2'b00; HRDATA = '0;
    repeat (2) @(negedge HCLK);
    total++;
    if (HTRANS !== 2'b00 || HADDR !== 0 || HWRITE !== 1'b0 || HSIZE !== 3'd0 ||
        HWDATA !== 0 || HBURST !== 3'b000) begin
      bad++;
      $display("FAIL reset_ahb: got trans=%b addr=%h wr=%b size=%0d wdata=%h burst=%b want all zero",
               HTRANS, HADDR, HWRITE, HSIZE, HWDATA, HBURST);
    end
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_rsp: got valid=%b rdata=%h err=%b req_ready=%b want 0/0/0/1",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    HRESET = 1'b0;
    @(negedge HCLK);
    $display("txn reset released");
  endtask

  task automatic test_read_zero_wait;
    int lat, iss, bc, bs; logic [31:0] rd; logic er;
    run_txn(0, 32'h0C00_0004, 3'd2, 32'h0, 0, 0, 0, 0, 32'h0000_00A5, 0,
            lat, iss, rd, er, bc, bs);
    $display("txn read_zero_wait lat=%0d issues=%0d rdata=%h err=%b", lat, iss, rd, er);
    total++;
    if (lat !== 3 || iss !== 1) begin
      bad++; $display("FAIL read0_timing: got lat=%0d issues=%0d want 3/1", lat, iss);
    end
    total++;
    if (rd !== 32'h0000_00A5 || er !== 1'b0) begin
      bad++; $display("FAIL read0_data: got rdata=%h err=%b want 000000a5/0", rd, er);
    end
    total++;
    if (bc !== 0) begin
      bad++; $display("FAIL read0_bus: got %0d bus violations want 0", bc);
    end
  endtask

  task automatic test_write_waits;
    int lat, iss, bc, bs; logic [31:0] rd; logic er;
    run_txn(1, 32'h0C00_2000, 3'd2, 32'hDEAD_BEEF, 0, 3, 0, 0, 32'h1234_5678, 0,
            lat, iss, rd, er, bc, bs);
    $display("txn write_3wait lat=%0d issues=%0d rdata=%h err=%b", lat, iss, rd, er);
    total++;
    if (lat !== 6 || rd !== 0 || er !== 1'b0) begin
      bad++; $display("FAIL write_wait: got lat=%0d rdata=%h err=%b want 6/0/0", lat, rd, er);
    end
    total++;
    if (bs !== 0 || bc !== 0) begin
      bad++; $display("FAIL write_hold: got hwdata_unstable=%0d bus=%0d want 0/0", bs, bc);
    end
  endtask

  task automatic test_error;
    int lat, iss, bc, bs; logic [31:0] rd; logic er;
    run_txn(0, 32'h0C00_0010, 3'd2, 32'h0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0,
            lat, iss, rd, er, bc, bs);
    $display("txn error lat=%0d rdata=%h err=%b", lat, rd, er);
    total++;
    if (lat !== 4 || rd !== 0 || er !== 1'b1 || bc !== 0) begin
      bad++; $display("FAIL error_resp: got lat=%0d rdata=%h err=%b bus=%0d want 4/0/1/0",
                      lat, rd, er, bc);
    end
    run_txn(0, 32'h0C00_0014, 3'd2, 32'h0, 0, 1, 0, 2, 32'hFFFF_FFFF, 0,
            lat, iss, rd, er, bc, bs);
    $display("txn error_hready_high lat=%0d rdata=%h err=%b", lat, rd, er);
    total++;
    if (lat !== 4 || rd !== 0 || er !== 1'b1) begin
      bad++; $display("FAIL error_violation: got lat=%0d rdata=%h err=%b want 4/0/1", lat, rd, er);
    end
  endtask

  task automatic test_retry;
    int lat, iss, bc, bs; logic [31:0] rd; logic er;
    run_txn(1, 32'h0C00_0100, 3'd2, 32'hCAFE_F00D, 0, 0, 99, 0, 32'h0, 0,
            lat, iss, rd, er, bc, bs);
    $display("txn retry_exhaust lat=%0d issues=%0d err=%b", lat, iss, er);
    total++;
    if (iss !== MAX_RETRY || er !== 1'b1 || rd !== 0 || lat !== 3 * MAX_RETRY + 1) begin
      bad++; $display("FAIL retry_exhaust: got issues=%0d err=%b rdata=%h lat=%0d want %0d/1/0/%0d",
                      iss, er, rd, lat, MAX_RETRY, 3 * MAX_RETRY + 1);
    end
    total++;
    if (bc !== 0 || bs !== 0) begin
      bad++; $display("FAIL retry_bus: got bus=%0d hwdata_unstable=%0d want 0/0", bc, bs);
    end
    // Counter must restart from zero: MAX_RETRY-1 retries still succeed.
    run_txn(0, 32'h0C00_0104, 3'd2, 32'h0, 0, 0, MAX_RETRY - 1, 0, 32'h0BAD_CAFE, 0,
            lat, iss, rd, er, bc, bs);
    $display("txn retry_then_ok lat=%0d issues=%0d rdata=%h err=%b", lat, iss, rd, er);
    total++;
    if (iss !== MAX_RETRY || er !== 1'b0 || rd !== 32'h0BAD_CAFE) begin
      bad++; $display("FAIL retry_reset: got issues=%0d err=%b rdata=%h want %0d/0/0bad_cafe",
                      iss, er, rd, MAX_RETRY);
    end
  endtask

  task automatic test_illegal;
    int lat, iss, bc, bs; logic [31:0] rd; logic er;
    logic [31:0] addrs [3] = '{32'h0C00_0002, 32'h0C00_0000, 32'h0C00_0001};
    logic [2:0]  sizes [3] = '{3'd2, 3'd3, 3'd1};
    for (int i = 0; i < 3; i++) begin
      run_txn(0, addrs[i], sizes[i], 32'h0, 0, 0, 0, 0, 32'h5555_5555, 0,
              lat, iss, rd, er, bc, bs);
      $display("txn illegal addr=%h size=%0d lat=%0d issues=%0d err=%b",
               addrs[i], sizes[i], lat, iss, er);
      total++;
      if (lat !== 1 || iss !== 0 || er !== 1'b1 || rd !== 0 || bc !== 0) begin
        bad++; $display("FAIL illegal_%0d: got lat=%0d issues=%0d err=%b rdata=%h bus=%0d want 1/0/1/0/0",
                        i, lat, iss, er, rd, bc);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat, iss, bc, bs; logic [31:0] rd; logic er;
    run_txn(0, 32'h0C00_0008, 3'd2, 32'h0, 1, 1, 0, 0, 32'h7777_0001, 5,
            lat, iss, rd, er, bc, bs);
    $display("txn backpressure lat=%0d rdata=%h err=%b", lat, rd, er);
    total++;
    if (bs !== 0 || bc !== 0 || rd !== 32'h7777_0001 || lat !== 5) begin
      bad++; $display("FAIL backpressure: got unstable=%0d bus=%0d rdata=%h lat=%0d want 0/0/77770001/5",
                      bs, bc, rd, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat, iss, bc, bs; logic [31:0] rd; logic er;
    for (int i = 0; i < 2; i++) begin
      run_txn(i[0], 32'h0C00_0020 + 32'(i * 4), 3'd2, 32'hA0A0_0000 + 32'(i), 0, 0, 0, 0,
              32'h0000_1000 + 32'(i), 0, lat, iss, rd, er, bc, bs);
      $display("txn back_to_back %0d lat=%0d rdata=%h err=%b", i, lat, rd, er);
      total++;
      if (lat !== 3 || bc !== 0 || er !== 1'b0 || rd !== ((i == 0) ? 32'h0000_1000 : 32'h0)) begin
        bad++; $display("FAIL back_to_back_%0d: got lat=%0d bus=%0d err=%b rdata=%h", i, lat, bc, er, rd);
      end
    end
  endtask

  task automatic test_random;
    int lat, iss, bc, bs, e_lat, e_iss, aw, nw, rt, kd, bp;
    logic [31:0] rd, e_rd, addr, wdata, rdata;
    logic er, e_er;
    logic [2:0] size;
    bit wr;
    for (int n = 0; n < 30; n++) begin
      wr    = 1'($urandom_range(0, 1));
      size  = 3'($urandom_range(0, 3));
      addr  = $urandom;
      if ($urandom_range(0, 4) != 0 && size <= 3'd2) addr = addr & ~((32'd1 << size) - 32'd1);
      wdata = $urandom; rdata = $urandom;
      aw = $urandom_range(0, 2); nw = $urandom_range(0, 3);
      rt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAX_RETRY + 1) : 0;
      kd = $urandom_range(0, 5); if (kd > 2) kd = 0;
      bp = $urandom_range(0, 2);
      model(wr, addr, size, aw, nw, rt, kd, rdata, e_lat, e_iss, e_rd, e_er);
      run_txn(wr, addr, size, wdata, aw, nw, rt, kd, rdata, bp, lat, iss, rd, er, bc, bs);
      $display("txn rand %0d wr=%b addr=%h size=%0d rt=%0d kind=%0d lat=%0d issues=%0d rdata=%h err=%b",
               n, wr, addr, size, rt, kd, lat, iss, rd, er);
      total++;
      if (lat !== e_lat || iss !== e_iss || rd !== e_rd || er !== e_er || bc !== 0 || bs !== 0) begin
        bad++;
        $display("FAIL rand_%0d: got lat=%0d iss=%0d rdata=%h err=%b bus=%0d unstable=%0d want lat=%0d iss=%0d rdata=%h err=%b",
                 n, lat, iss, rd, er, bc, bs, e_lat, e_iss, e_rd, e_er);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit seen_rsp;
    @(negedge HCLK);
    req_valid = 1'b1; req_wr1_rd0 = 1'b1; req_addr = 32'h0C00_0040; req_size = 3'd2;
    req_wdata = 32'h1111_2222; HREADY = 1'b1; HRESP = 2'b00; rsp_ready = 1'b1;
    @(negedge HCLK);                 // address phase
    req_valid = 1'b0;
    @(negedge HCLK);                 // data phase, slave stalls
    HREADY = 1'b0;
    total++;
    if (HTRANS !== 2'b00 || HWDATA !== 32'h1111_2222) begin
      bad++; $display("FAIL reset_mid_pre: got trans=%b hwdata=%h want 00/11112222", HTRANS, HWDATA);
    end
    #2 HRESET = 1'b1;
    #1;
    total++;
    if (HTRANS !== 2'b00 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || HWDATA !== 0) begin
      bad++; $display("FAIL reset_mid_now: got trans=%b rsp_valid=%b req_ready=%b hwdata=%h want 00/0/1/0",
                      HTRANS, rsp_valid, req_ready, HWDATA);
    end
    @(negedge HCLK);
    HRESET = 1'b0; HREADY = 1'b1;
    seen_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) seen_rsp = 1;
    end
    $display("txn reset_mid stray_activity=%0d", seen_rsp);
    total++;
    if (seen_rsp) begin
      bad++; $display("FAIL reset_mid_after: got stray response or transfer after reset want none");
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_error();
    test_retry();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
